// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types and constants: FSM state encoding, prefix bytes, frame length.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_sync_filter.sv
// Brings the raw PS/2 pins into the clk domain and de-glitches the device clock,
// producing a one-cycle fall pulse on each filtered 1->0 clock transition.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic PS2_CLK,
  input  logic PS2_DAT,
  output logic dat_s,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_filt;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronised samples that disagree with clk_filt
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_filt <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
      fall     <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        cnt      <= '0;
        fall     <= ~clk_sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign dat_s = dat_sync[1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: frame deserialiser with timeout, plus E0/F0 prefix decoder
// that turns raw bytes into one scan-code event per key action.
module ps2_rx import ps2_pkg::*; #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] raw_byte,
  output logic       raw_valid,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       frame_err,
  output ps2_state_t state
);

  // Handshake: raw_valid, scan_valid and frame_err are single-cycle pulses with no
  // backpressure; raw_byte and scan_code/is_break/is_extended hold until the next pulse.

  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DATA_BITS = PS2_FRAME_BITS - 3;

  logic          dat_s;
  logic          fall;
  ps2_state_t    state_nxt;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          stop_fall;
  logic          good;
  logic          ext_flag;
  logic          brk_flag;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .PS2_CLK (PS2_CLK),
    .PS2_DAT (PS2_DAT),
    .dat_s   (dat_s),
    .fall    (fall)
  );

  always_comb begin
    state_nxt = state;
    stop_fall = 1'b0;
    good      = 1'b0;
    timeout   = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    case (state)
      IDLE:   if (fall && !dat_s) state_nxt = DATA;
      DATA:   if (fall && bitcnt == 3'(DATA_BITS - 1)) state_nxt = PARITY;
      PARITY: if (fall) state_nxt = STOP;
      STOP: begin
        if (fall) begin
          state_nxt = IDLE;
          stop_fall = 1'b1;
          good      = (^{shreg, par}) && dat_s;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      bitcnt      <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      tcnt        <= '0;
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      raw_byte    <= '0;
      raw_valid   <= 1'b0;
      scan_code   <= '0;
      scan_valid  <= 1'b0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      raw_valid  <= 1'b0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (fall || state_nxt == IDLE) tcnt <= '0;
      else                           tcnt <= tcnt + 1'b1;

      if (state == IDLE) bitcnt <= '0;
      if (fall) begin
        case (state)
          DATA: begin
            shreg[bitcnt] <= dat_s;
            bitcnt        <= bitcnt + 1'b1;
          end
          PARITY:  par <= dat_s;
          default: ;
        endcase
      end

      // Any error drops pending prefixes so they cannot attach to an unrelated code
      if (timeout || (stop_fall && !good)) begin
        frame_err <= 1'b1;
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
      end else if (good) begin
        raw_valid <= 1'b1;
        raw_byte  <= shreg;
        if (shreg == PS2_PREFIX_EXT) begin
          ext_flag <= 1'b1;
        end else if (shreg == PS2_PREFIX_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          scan_valid  <= 1'b1;
          scan_code   <= shreg;
          is_break    <= brk_flag;
          is_extended <= ext_flag;
          ext_flag    <= 1'b0;
          brk_flag    <= 1'b0;
        end
      end
    end
  end

endmodule
